ibpl_gpio_cardlet: RTL and testbench

Parametrised general-purpose I/O cardlet plugin for the DIOB2 interbackplane frontend. It replaces the fixed all-zero default with up to 6 supported channels, each driven or read according to the per-channel enables. Inputs are synchronised and debounced, and each channel gets an activity LED with pulse stretching. Illegal enable requests raise a sticky `plugin_error`, and the block forces all drivers off while the error condition is present.

---
 rtl/ibpl_gpio_cardlet.sv | 143 ++++++++++++++
 tb/tb_ibpl_gpio_cardlet.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibpl_gpio_cardlet.sv
// GPIO cardlet plugin for the DIOB2 interbackplane frontend: per-channel drive/read,
// synchronised and debounced inputs, stretched activity LEDs and a sticky enable error.
module ibpl_gpio_cardlet #(
    parameter int unsigned CH_COUNT           = 6,
    parameter int unsigned DEBOUNCE_CYCLES    = 16,
    parameter int unsigned LED_STRETCH_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] output_enable,
    input  logic [7:0] input_enable,
    input  logic [7:0] internal_out,
    input  logic [5:0] diob_in,
    input  logic       error_clear,
    output logic [5:0] diob_dir,
    output logic [5:0] diob_out,
    output logic [7:0] internal_in,
    output logic [7:0] diob_led1,
    output logic [7:0] diob_led2,
    output logic       plugin_error
);

    localparam int unsigned NCH   = 6;
    localparam int unsigned EN_W  = 8;
    localparam int unsigned LED_W = 24;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [EN_W-1:0]  SUP_MASK = EN_W'((64'd1 << CH_COUNT) - 64'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LED_W-1:0] LED_LOAD = LED_W'(LED_STRETCH_CYCLES);

    logic [EN_W-1:0]  oe_q, ie_q;
    logic             err_q, err_d;
    logic [NCH-1:0]   dout_q, dout_d;
    logic [NCH-1:0]   s1_q, s2_q;
    logic [NCH-1:0]   deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [NCH-1:0]   src_q;
    logic [LED_W-1:0] led_q [NCH];
    logic [LED_W-1:0] led_d [NCH];

    logic [NCH-1:0]   out_mode, in_mode, led_src, led_on;
    logic             err_cond;
    logic             unused_int_out;

    // Channel mode decode from the registered enables; unsupported channels stay idle.
    assign out_mode = oe_q[NCH-1:0] & ~ie_q[NCH-1:0] & SUP_MASK[NCH-1:0];
    assign in_mode  = ie_q[NCH-1:0] & ~oe_q[NCH-1:0] & SUP_MASK[NCH-1:0];
    assign err_cond = (|(oe_q & ie_q & SUP_MASK)) | (|((oe_q | ie_q) & ~SUP_MASK));
    assign led_src  = (out_mode & dout_q) | (in_mode & deb_q);

    assign unused_int_out = ^internal_out[EN_W-1:NCH];

    // Error flag: a live error condition always wins over a clear request.
    always_comb begin
        err_d = err_q;
        if (err_cond) begin
            err_d = 1'b1;
        end else if (error_clear) begin
            err_d = 1'b0;
        end
    end

    assign dout_d = internal_out[NCH-1:0] & out_mode;

    // Debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (DEBOUNCE_CYCLES == 0) begin
            deb_d = s2_q;
            for (int i = 0; i < NCH; i++) begin
                cnt_d[i] = '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (s2_q[i] == deb_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = s2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Activity LED stretch: any source edge reloads, otherwise count down to dark.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            led_d[i]  = led_q[i];
            led_on[i] = |led_q[i];
            if (led_src[i] != src_q[i]) begin
                led_d[i] = LED_LOAD;
            end else if (led_q[i] != '0) begin
                led_d[i] = led_q[i] - LED_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            oe_q   <= '0;
            ie_q   <= '0;
            err_q  <= 1'b0;
            dout_q <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            deb_q  <= '0;
            src_q  <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
                led_q[i] <= '0;
            end
        end else begin
            oe_q   <= output_enable;
            ie_q   <= input_enable;
            err_q  <= err_d;
            dout_q <= dout_d;
            s1_q   <= diob_in;
            s2_q   <= s1_q;
            deb_q  <= deb_d;
            src_q  <= led_src;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
                led_q[i] <= led_d[i];
            end
        end
    end

    // Drivers are forced off only while the error condition itself is present.
    assign diob_dir     = err_cond ? '0 : out_mode;
    assign diob_out     = dout_q;
    assign internal_in  = {2'b00, deb_q & in_mode};
    assign diob_led1    = {err_q, 1'b0, led_on};
    assign diob_led2    = {2'b00, diob_dir};
    assign plugin_error = err_q;

endmodule

// File: tb/tb_ibpl_gpio_cardlet.sv
// Bench for ibpl_gpio_cardlet: two instances (6 and 4 channels) share stimulus and are
// compared every cycle against a behavioural model, plus directed checks.
module tb_ibpl_gpio_cardlet;

    localparam int unsigned DEB = 4;
    localparam int unsigned STR = 8;

    logic       clk;
    logic       reset;
    logic [7:0] output_enable, input_enable, internal_out;
    logic [5:0] diob_in;
    logic       error_clear;

    logic [5:0] dir_o  [2];
    logic [5:0] out_o  [2];
    logic [7:0] iin_o  [2];
    logic [7:0] led1_o [2];
    logic [7:0] led2_o [2];
    logic       pe_o   [2];

    int vectors;
    int miscompares;

    // Behavioural model state, index 0 = 6-channel, 1 = 4-channel instance
    logic [7:0] m_oe [2];
    logic [7:0] m_ie [2];
    logic       m_pe [2];
    logic [5:0] m_out [2];
    logic [5:0] m_s1 [2];
    logic [5:0] m_s2 [2];
    logic [5:0] m_deb [2];
    logic [5:0] m_prev [2];
    int         m_run [2][6];
    int         m_led [2][6];

    ibpl_gpio_cardlet #(.CH_COUNT(6), .DEBOUNCE_CYCLES(DEB), .LED_STRETCH_CYCLES(STR)) u_dut6 (
        .clk(clk), .reset(reset), .output_enable(output_enable), .input_enable(input_enable),
        .internal_out(internal_out), .diob_in(diob_in), .error_clear(error_clear),
        .diob_dir(dir_o[0]), .diob_out(out_o[0]), .internal_in(iin_o[0]),
        .diob_led1(led1_o[0]), .diob_led2(led2_o[0]), .plugin_error(pe_o[0])
    );

    ibpl_gpio_cardlet #(.CH_COUNT(4), .DEBOUNCE_CYCLES(DEB), .LED_STRETCH_CYCLES(STR)) u_dut4 (
        .clk(clk), .reset(reset), .output_enable(output_enable), .input_enable(input_enable),
        .internal_out(internal_out), .diob_in(diob_in), .error_clear(error_clear),
        .diob_dir(dir_o[1]), .diob_out(out_o[1]), .internal_in(iin_o[1]),
        .diob_led1(led1_o[1]), .diob_led2(led2_o[1]), .plugin_error(pe_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ch_of(input int m);
        return (m == 0) ? 6 : 4;
    endfunction

    function automatic logic [5:0] f_om(input int m);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = (i < ch_of(m)) && m_oe[m][i] && !m_ie[m][i];
        return r;
    endfunction

    function automatic logic [5:0] f_im(input int m);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = (i < ch_of(m)) && m_ie[m][i] && !m_oe[m][i];
        return r;
    endfunction

    function automatic logic f_err(input int m);
        logic e;
        e = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < ch_of(m)) begin
                if (m_oe[m][i] && m_ie[m][i]) e = 1'b1;
            end else if (m_oe[m][i] || m_ie[m][i]) begin
                e = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                m_oe[m] = '0; m_ie[m] = '0; m_pe[m] = 1'b0; m_out[m] = '0;
                m_s1[m] = '0; m_s2[m] = '0; m_deb[m] = '0; m_prev[m] = '0;
                for (int i = 0; i < 6; i++) begin
                    m_run[m][i] = 0;
                    m_led[m][i] = 0;
                end
            end else begin
                logic [5:0] om, im;
                logic       e;
                om = f_om(m);
                im = f_im(m);
                e  = f_err(m);
                for (int i = 0; i < 6; i++) begin
                    logic src;
                    src = om[i] ? m_out[m][i] : (im[i] ? m_deb[m][i] : 1'b0);
                    if (src != m_prev[m][i]) m_led[m][i] = STR;
                    else if (m_led[m][i] > 0) m_led[m][i] = m_led[m][i] - 1;
                    m_prev[m][i] = src;
                    if (m_s2[m][i] == m_deb[m][i]) begin
                        m_run[m][i] = 0;
                    end else begin
                        m_run[m][i] = m_run[m][i] + 1;
                        if (m_run[m][i] >= DEB) begin
                            m_deb[m][i] = m_s2[m][i];
                            m_run[m][i] = 0;
                        end
                    end
                end
                m_out[m] = internal_out[5:0] & om;
                if (e) m_pe[m] = 1'b1;
                else if (error_clear) m_pe[m] = 1'b0;
                m_s2[m] = m_s1[m];
                m_s1[m] = diob_in;
                m_oe[m] = output_enable;
                m_ie[m] = input_enable;
            end
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            logic [5:0] e_dir, ledon;
            e_dir = f_err(m) ? 6'h00 : f_om(m);
            for (int i = 0; i < 6; i++) ledon[i] = (m_led[m][i] != 0);
            check($sformatf("dut%0d_dir", ch_of(m)), 8'(dir_o[m]), 8'(e_dir));
            check($sformatf("dut%0d_out", ch_of(m)), 8'(out_o[m]), 8'(m_out[m]));
            check($sformatf("dut%0d_iin", ch_of(m)), iin_o[m], {2'b00, m_deb[m] & f_im(m)});
            check($sformatf("dut%0d_led1", ch_of(m)), led1_o[m], {m_pe[m], 1'b0, ledon});
            check($sformatf("dut%0d_led2", ch_of(m)), led2_o[m], {2'b00, e_dir});
            check($sformatf("dut%0d_perr", ch_of(m)), 8'(pe_o[m]), 8'(m_pe[m]));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int c0, c2;
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        output_enable = '0; input_enable = '0; internal_out = '0;
        diob_in = '0; error_clear = 1'b0;

        // Reset and idle
        cycle(); cycle();
        reset = 1'b0;
        for (int j = 0; j < 10; j++) cycle();
        check("idle_perr", 8'(pe_o[0]), 8'h00);
        check("idle_led1", led1_o[0], 8'h00);

        // Output mode on channels 0 and 2
        output_enable = 8'h05; internal_out = 8'h3F;
        cycle();
        check("out_dir", 8'(dir_o[0]), 8'h05);
        check("out_led2", led2_o[0], 8'h05);
        cycle();
        check("out_data", 8'(out_o[0]), 8'h05);
        c0 = 0; c2 = 0;
        for (int j = 0; j < 12; j++) begin
            cycle();
            if (led1_o[0][0]) c0++;
            if (led1_o[0][2]) c2++;
        end
        check("led0_len", 8'(c0), 8'(STR));
        check("led2_len", 8'(c2), 8'(STR));

        // Input mode on channel 1: short glitch rejected, long level accepted
        output_enable = 8'h00; input_enable = 8'h02; internal_out = 8'h00;
        for (int j = 0; j < 12; j++) cycle();
        diob_in = 6'h02;
        for (int j = 0; j < 3; j++) cycle();
        diob_in = 6'h00;
        for (int j = 0; j < 10; j++) cycle();
        check("glitch_iin", iin_o[0], 8'h00);
        diob_in = 6'h02;
        for (int j = 1; j <= 10; j++) begin
            cycle();
            if (j == 5) check("deb_early", iin_o[0], 8'h00);
            if (j == 6) check("deb_accept", iin_o[0], 8'h02);
        end

        // Unsupported channel on the 4-channel instance
        input_enable = 8'h00; output_enable = 8'h10;
        cycle();
        check("unsup_dir", 8'(dir_o[1]), 8'h00);
        cycle();
        check("unsup_perr", 8'(pe_o[1]), 8'h01);
        error_clear = 1'b1;
        cycle();
        error_clear = 1'b0;
        check("clr_blocked", 8'(pe_o[1]), 8'h01);
        output_enable = 8'h00;
        cycle(); cycle(); cycle();
        check("sticky", 8'(pe_o[1]), 8'h01);
        error_clear = 1'b1;
        cycle();
        error_clear = 1'b0;
        check("cleared", 8'(pe_o[1]), 8'h00);

        // Conflict on channel 0
        output_enable = 8'h01; input_enable = 8'h01; internal_out = 8'h01;
        cycle();
        check("conf_dir", 8'(dir_o[0]), 8'h00);
        cycle();
        check("conf_perr", 8'(pe_o[0]), 8'h01);
        check("conf_led7", 8'(led1_o[0][7]), 8'h01);
        check("conf_iin", iin_o[0], 8'h00);

        // Reset mid-debounce and mid-stretch, then no stale accept
        output_enable = 8'h00; input_enable = 8'h00; error_clear = 1'b1;
        cycle(); cycle();
        error_clear = 1'b0;
        output_enable = 8'h01; input_enable = 8'h02; internal_out = 8'h01; diob_in = 6'h00;
        for (int j = 0; j < 8; j++) cycle();
        diob_in = 6'h02;
        for (int j = 0; j < 3; j++) cycle();
        reset = 1'b1; diob_in = 6'h00;
        cycle();
        check("rst_out", 8'(out_o[0]), 8'h00);
        check("rst_led1", led1_o[0], 8'h00);
        check("rst_iin", iin_o[0], 8'h00);
        reset = 1'b0;
        for (int j = 0; j < 10; j++) cycle();
        check("no_stale", iin_o[0], 8'h00);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            internal_out = 8'($urandom);
            if ($urandom_range(15) == 0) begin
                case ($urandom_range(3))
                    0: begin
                        output_enable = 8'($urandom) & 8'h3F;
                        input_enable  = ~output_enable & 8'($urandom) & 8'h3F;
                    end
                    1: begin
                        output_enable = 8'($urandom);
                        input_enable  = 8'($urandom);
                    end
                    2: begin
                        output_enable = 8'h00;
                        input_enable  = 8'($urandom) & 8'h0F;
                    end
                    default: begin
                        output_enable = 8'($urandom) & 8'h0F;
                        input_enable  = 8'h00;
                    end
                endcase
            end
            error_clear = ($urandom_range(7) == 0);
            reset = ($urandom_range(199) == 0);
            for (int b = 0; b < 6; b++) begin
                if ($urandom_range(11) == 0) diob_in[b] = ~diob_in[b];
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
